// File: rtl/window_buffer_5x5.sv
// Sliding 5x5 pixel window built from five vertically aligned row streams.
// A column enters on each valid beat. done_o marks a complete in-row window; progress_done_o marks the frame's last window.
module window_buffer_5x5 #(
    parameter int COLS = 7,
    parameter int ROWS = 7
) (
    input  logic       clk,
    input  logic       rst,
    // done_i qualifies S1_i..S5_i for one beat. There is no ready: every valid beat is consumed on that edge.
    input  logic       done_i,
    input  logic [7:0] S1_i,
    input  logic [7:0] S2_i,
    input  logic [7:0] S3_i,
    input  logic [7:0] S4_i,
    input  logic [7:0] S5_i,
    output logic [7:0] S1_o,
    output logic [7:0] S2_o,
    output logic [7:0] S3_o,
    output logic [7:0] S4_o,
    output logic [7:0] S5_o,
    output logic [7:0] S6_o,
    output logic [7:0] S7_o,
    output logic [7:0] S8_o,
    output logic [7:0] S9_o,
    output logic [7:0] S10_o,
    output logic [7:0] S11_o,
    output logic [7:0] S12_o,
    output logic [7:0] S13_o,
    output logic [7:0] S14_o,
    output logic [7:0] S15_o,
    output logic [7:0] S16_o,
    output logic [7:0] S17_o,
    output logic [7:0] S18_o,
    output logic [7:0] S19_o,
    output logic [7:0] S20_o,
    output logic [7:0] S21_o,
    output logic [7:0] S22_o,
    output logic [7:0] S23_o,
    output logic [7:0] S24_o,
    output logic [7:0] S25_o,
    output logic       done_o,
    output logic       progress_done_o
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST      = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(4);
    localparam logic [RW-1:0] ROW_LAST      = RW'(ROWS - 5);

    logic [7:0]    win [0:4][0:4];
    logic [7:0]    s_col [0:4];
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign s_col[0] = S1_i;
    assign s_col[1] = S2_i;
    assign s_col[2] = S3_i;
    assign s_col[3] = S4_i;
    assign s_col[4] = S5_i;

    // Window registers are left alone at row start; done_o masks the stale columns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win[r][c] <= '0;
                end
            end
            col             <= '0;
            row             <= '0;
            done_o          <= 1'b0;
            progress_done_o <= 1'b0;
        end else begin
            done_o          <= done_i && (col >= COL_FIRST_WIN);
            progress_done_o <= done_i && (col == COL_LAST) && (row == ROW_LAST);
            if (done_i) begin
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                    win[r][4] <= s_col[r];
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign S1_o  = win[0][0];
    assign S2_o  = win[0][1];
    assign S3_o  = win[0][2];
    assign S4_o  = win[0][3];
    assign S5_o  = win[0][4];
    assign S6_o  = win[1][0];
    assign S7_o  = win[1][1];
    assign S8_o  = win[1][2];
    assign S9_o  = win[1][3];
    assign S10_o = win[1][4];
    assign S11_o = win[2][0];
    assign S12_o = win[2][1];
    assign S13_o = win[2][2];
    assign S14_o = win[2][3];
    assign S15_o = win[2][4];
    assign S16_o = win[3][0];
    assign S17_o = win[3][1];
    assign S18_o = win[3][2];
    assign S19_o = win[3][3];
    assign S20_o = win[3][4];
    assign S21_o = win[4][0];
    assign S22_o = win[4][1];
    assign S23_o = win[4][2];
    assign S24_o = win[4][3];
    assign S25_o = win[4][4];

endmodule

// File: tb/tb_window_buffer_5x5.sv
// Directed bench for window_buffer_5x5 at COLS=7, ROWS=7; every beat drives S1_i..S5_i with the beat value.
// After a window beat v, every row of the window should read v-4 .. v from left to right.
module tb_window_buffer_5x5;

    logic       clk;
    logic       rst;
    logic       done_i;
    logic [7:0] s_in;
    logic [7:0] o [0:24];
    logic       done_o;
    logic       progress_done_o;

    int passed = 0;
    int total  = 0;

    window_buffer_5x5 #(.COLS(7), .ROWS(7)) dut (
        .clk(clk), .rst(rst), .done_i(done_i),
        .S1_i(s_in), .S2_i(s_in), .S3_i(s_in), .S4_i(s_in), .S5_i(s_in),
        .S1_o(o[0]),   .S2_o(o[1]),   .S3_o(o[2]),   .S4_o(o[3]),   .S5_o(o[4]),
        .S6_o(o[5]),   .S7_o(o[6]),   .S8_o(o[7]),   .S9_o(o[8]),   .S10_o(o[9]),
        .S11_o(o[10]), .S12_o(o[11]), .S13_o(o[12]), .S14_o(o[13]), .S15_o(o[14]),
        .S16_o(o[15]), .S17_o(o[16]), .S18_o(o[17]), .S19_o(o[18]), .S20_o(o[19]),
        .S21_o(o[20]), .S22_o(o[21]), .S23_o(o[22]), .S24_o(o[23]), .S25_o(o[24]),
        .done_o(done_o), .progress_done_o(progress_done_o)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Checks
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic exp_done, input logic exp_pd);
        check({tag, " done_o"}, {7'd0, done_o}, {7'd0, exp_done});
        check({tag, " progress_done_o"}, {7'd0, progress_done_o}, {7'd0, exp_pd});
    endtask

    // Window whose oldest column holds base: each row reads base..base+4.
    task automatic check_win(input string tag, input int base);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                check($sformatf("%s S%0d_o", tag, 5 * r + c + 1), o[5 * r + c], 8'(base + c));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 25; k++) begin
            check($sformatf("%s S%0d_o", tag, k + 1), o[k], 8'd0);
        end
    endtask

    // Drivers
    task automatic beat(input int v);
        @(negedge clk);
        done_i = 1'b1;
        s_in   = 8'(v);
        @(posedge clk);
        #1;
        done_i = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        done_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        done_i = 1'b0;
        s_in   = 8'd0;

        // Reset held across several edges, then released with no traffic
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        check_flags("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        idle();
        check_zero("post_reset_idle");
        check_flags("post_reset_idle", 1'b0, 1'b0);

        // First window of row 0
        for (int v = 1; v <= 4; v++) begin
            beat(v);
            check_flags($sformatf("beat%0d", v), 1'b0, 1'b0);
        end
        beat(5);
        check_flags("beat5", 1'b1, 1'b0);
        check_win("win1", 1);

        // Rest of row 0, masked start of row 1
        beat(6);
        check_flags("beat6", 1'b1, 1'b0);
        check_win("win2", 2);
        beat(7);
        check_flags("beat7", 1'b1, 1'b0);
        check_win("win3", 3);
        for (int v = 8; v <= 11; v++) begin
            beat(v);
            check_flags($sformatf("beat%0d", v), 1'b0, 1'b0);
        end
        beat(12);
        check_flags("beat12", 1'b1, 1'b0);
        check_win("win8", 8);
        beat(13);
        check_flags("beat13", 1'b1, 1'b0);
        check_win("win9", 9);

        // Mid-row gap: content frozen, done_o low
        for (int g = 0; g < 3; g++) begin
            idle();
            check_flags($sformatf("gap%0d", g), 1'b0, 1'b0);
        end
        check_win("gap_hold", 9);
        beat(14);
        check_flags("beat14", 1'b1, 1'b0);
        check_win("win10", 10);

        // Last window row of the frame
        for (int v = 15; v <= 18; v++) begin
            beat(v);
            check_flags($sformatf("beat%0d", v), 1'b0, 1'b0);
        end
        beat(19);
        check_flags("beat19", 1'b1, 1'b0);
        beat(20);
        check_flags("beat20", 1'b1, 1'b0);
        beat(21);
        check_flags("beat21", 1'b1, 1'b1);
        check_win("win17", 17);

        // Next frame starts without reset
        for (int v = 22; v <= 25; v++) begin
            beat(v);
            check_flags($sformatf("beat%0d", v), 1'b0, 1'b0);
        end
        beat(26);
        check_flags("beat26", 1'b1, 1'b0);
        check_win("win22", 22);
        beat(27);
        check_flags("beat27", 1'b1, 1'b0);
        beat(28);
        check_flags("beat28", 1'b1, 1'b0);
        check_win("win24", 24);
        idle();
        check_flags("after_frame2_row0", 1'b0, 1'b0);

        // Async reset mid-row while done_o is high
        for (int v = 29; v <= 32; v++) begin
            beat(v);
        end
        beat(33);
        check_flags("beat33", 1'b1, 1'b0);
        check_win("win29", 29);
        #2;
        rst = 1'b0;
        #1;
        check_flags("async_reset", 1'b0, 1'b0);
        check_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int v = 40; v <= 43; v++) begin
            beat(v);
            check_flags($sformatf("rerun%0d", v), 1'b0, 1'b0);
        end
        beat(44);
        check_flags("rerun44", 1'b1, 1'b0);
        check_win("win40", 40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/window_buffer_5x5.md
Name: window_buffer_5x5

Overview:
- Forms a sliding 5x5 pixel window from five vertically aligned row streams supplied by upstream line buffers.
- Each valid beat delivers one column (five pixels, one per row) and shifts it into a 5x5 register array.
- Flags when the array holds a complete window within the current image row.
- Flags when the last window of the frame has been produced.
- Feeds 5x5 filter kernels downstream.

Parameters:
- COLS, default 7: image width in pixels (columns per row); must be at least 5.
- ROWS, default 7: image height in pixels; must be at least 5; window rows per frame = ROWS-4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- done_i  input  1  input valid; S1_i..S5_i carry one column this cycle.
- S1_i..S5_i  input  8 each  column pixels; S1_i is the top window row, S5_i the bottom.
- S1_o..S25_o  output  8 each  window pixels, row-major.
  - S(5*(r-1)+c)_o is row r (1..5, from S(r)_i) and column c (1..5).
  - c=1 is the oldest column; c=5 is the newest.
- done_o  output  1  window valid this cycle.
- progress_done_o  output  1  one-cycle pulse marking the final window of the frame.

Behaviour:
- Reset (rst low, asynchronous):
  - All 25 window registers = 0.
  - done_o = 0, progress_done_o = 0.
  - Column counter = 0, window-row counter = 0.
- Shift, on a rising edge with done_i=1, for each row r:
  - Column 1 takes column 2, column 2 takes 3, column 3 takes 4, column 4 takes 5.
  - Column 5 takes S(r)_i.
- Hold: with done_i=0, window registers and counters hold; done_o=0 and progress_done_o=0 on the next edge.
- Column counter col (0..COLS-1):
  - Increments on each valid beat.
  - Wraps to 0 after COLS-1; on wrap, the window-row counter increments.
- done_o:
  - Registered; set on the edge of a valid beat whose pre-increment col is >= 4, else cleared.
  - One-cycle latency: done_o is high in the cycle after the fifth, sixth, ..., COLS-th beat of a row, coincident with the updated window.
  - Yields COLS-4 valid windows per image row.
- Row boundary: window registers are not cleared at row start. Stale columns from the previous row stay visible but are masked because done_o stays low for the first 4 beats of each row.
- progress_done_o:
  - Registered; pulses high for one cycle together with done_o.
  - Fires on the beat where col = COLS-1 and window-row counter = ROWS-5, i.e. the (ROWS-4)*COLS-th valid beat of the frame.
  - On that beat both counters return to 0, ready for the next frame with no reset needed.
- Gaps: done_i may drop at any beat, including mid-row. Counters resume on the next valid beat; the window content is contiguous in valid beats, not clock cycles.
- Reset mid-frame: counters and outputs return to reset values immediately; the next valid beat is treated as column 0 of window row 0.
- No stall input; the downstream consumer must accept one window per valid beat.
- Pixels are passed through unmodified; no arithmetic.

Test Plan (COLS=7, ROWS=7, each beat drives S1_i..S5_i = i):
- Reset: hold rst low, toggle clk -> all S*_o = 0, done_o = 0, progress_done_o = 0; outputs stay 0 after release with done_i=0.
- First window: beats i=1..5 -> after beat 5 edge, done_o=1 and each row reads 1,2,3,4,5 (S1_o=1, S5_o=5, S21_o=1, S25_o=5); done_o=0 after beats 1..4.
- Row sweep:
  - Beats 6,7 -> done_o=1 with rows 2..6 then 3..7.
  - Beats 8..11 -> done_o=0.
  - Beat 12 -> done_o=1 with rows 8..12.
  - Beats 13,14 -> windows 9..13 and 10..14.
- Gap: drop done_i for 3 cycles after beat 13, then resume with 14 -> done_o low during the gap; the window after 14 reads 10..14; register contents unchanged during the gap.
- Frame end: beats i=1..21 -> progress_done_o pulses exactly once, after beat 21, with done_o=1 and rows 17..21. Beats 22..26 then behave as a new frame (first done_o after beat 26, window 22..26).
- Async reset: assert rst low mid-row between clock edges -> outputs clear immediately; a subsequent 5-beat run produces its first window after the fifth beat.
